// File: rtl/mtr_ramp_ctrl_pkg.sv
// Shared types and limits for the motor ramp controller.
// Speeds are signed 11-bit, symmetric range +/-1023.
package mtr_ctrl_pkg;

   typedef logic signed [10:0] spd_t;

   typedef enum logic [1:0] {
      IDLE,
      RAMP,
      HOLD,
      STOP
   } state_t;

   localparam spd_t SPD_MAX = 11'sd1023;
   localparam spd_t SPD_MIN = -11'sd1023;

   // -1024 has no positive mirror, so fold it onto -1023
   function automatic spd_t clamp_cmd(spd_t v);
      return (v < SPD_MIN) ? SPD_MIN : v;
   endfunction

endpackage

// File: rtl/mtr_ramp_ctrl_spd_slew.sv
// Per-wheel slew limiter: walks cur toward tgt by at most STEP per tick.
// MTR_DEADBAND_EN adds a zero-hold of DB_TICKS ticks on direction reversal.
module spd_slew
   import mtr_ctrl_pkg::*;
#(
   parameter int STEP     = 16,
   parameter int DB_TICKS = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               slew_en,
   input  logic               clr,
   input  logic signed [10:0] tgt,
   output logic signed [10:0] cur,
   output logic               hold
);

   localparam spd_t STEP_S = 11'(STEP);

   logic signed [11:0] diff;
   logic signed [11:0] step12;
   spd_t               nxt;

   assign step12 = 12'(STEP);
   assign diff   = {tgt[10], tgt} - {cur[10], cur};

   always_comb begin
      nxt = tgt;
      if (diff > step12) begin
         nxt = cur + STEP_S;
      end else if (diff < -step12) begin
         nxt = cur - STEP_S;
      end
   end

`ifdef MTR_DEADBAND_EN
   localparam int DBW = (DB_TICKS < 2) ? 1 : $clog2(DB_TICKS + 1);

   logic [DBW-1:0] db_cnt;
   logic           cross;
   logic           near0;

   // reversal only matters once the next step would reach or pass zero
   assign near0 = cur[10] ? (-cur <= STEP_S) : (cur <= STEP_S);
   assign cross = (cur != '0) && (tgt != '0) && (cur[10] != tgt[10]) && near0;
   assign hold  = (db_cnt != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur    <= '0;
         db_cnt <= '0;
      end else if (clr) begin
         cur    <= '0;
         db_cnt <= '0;
      end else if (tick && slew_en) begin
         if (hold) begin
            db_cnt <= db_cnt - DBW'(1);
         end else if (cross) begin
            cur    <= '0;
            db_cnt <= DBW'(DB_TICKS);
         end else begin
            cur <= nxt;
         end
      end
   end
`else
   assign hold = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur <= '0;
      end else if (clr) begin
         cur <= '0;
      end else if (tick && slew_en) begin
         cur <= nxt;
      end
   end
`endif

endmodule

// File: rtl/mtr_ramp_ctrl.sv
// Slew-rate-limited wheel speed scheduler: FSM, tick prescaler, targets.
// Optional direction-reversal deadband via MTR_DEADBAND_EN.
module mtr_ramp_ctrl
   import mtr_ctrl_pkg::*;
#(
   parameter int TICK_DIV = 1024,
   parameter int STEP     = 16,
   parameter int DB_TICKS = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               e_stop,
   input  logic               cmd_vld,
   input  logic signed [10:0] lft_cmd,
   input  logic signed [10:0] rght_cmd,
   output logic signed [10:0] lft_spd,
   output logic signed [10:0] rght_spd,
   output logic               at_target,
   output logic               busy
);

   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] tcnt;
   logic          tick;
   state_t        state;
   state_t        state_nxt;
   spd_t          lft_tgt;
   spd_t          rght_tgt;
   spd_t          lft_new;
   spd_t          rght_new;
   spd_t          lft_eff;
   spd_t          rght_eff;
   logic          drive;
   logic          lft_hold;
   logic          rght_hold;
   logic          done;

   assign tick = (tcnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt <= '0;
      end else begin
         tcnt <= tick ? '0 : tcnt + CW'(1);
      end
   end

   assign lft_new  = clamp_cmd(lft_cmd);
   assign rght_new = clamp_cmd(rght_cmd);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lft_tgt  <= '0;
         rght_tgt <= '0;
      end else if (cmd_vld) begin
         lft_tgt  <= lft_new;
         rght_tgt <= rght_new;
      end
   end

   assign drive    = (state == RAMP) || (state == HOLD);
   assign lft_eff  = drive ? lft_tgt : '0;
   assign rght_eff = drive ? rght_tgt : '0;
   assign busy     = (state == RAMP) || (state == STOP);

   // a wheel parked in its deadband is never considered on target
   assign done = (lft_spd == lft_eff) && (rght_spd == rght_eff)
              && !lft_hold && !rght_hold;
   assign at_target = done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (e_stop) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (en) state_nxt = RAMP;
            RAMP: begin
               if (!en)           state_nxt = STOP;
               else if (cmd_vld)  state_nxt = RAMP;
               else if (done)     state_nxt = HOLD;
            end
            HOLD: begin
               if (!en) begin
                  state_nxt = STOP;
               end else if (cmd_vld &&
                            (lft_new != lft_spd || rght_new != rght_spd)) begin
                  state_nxt = RAMP;
               end
            end
            STOP: begin
               if (en)        state_nxt = RAMP;
               else if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   spd_slew #(.STEP(STEP), .DB_TICKS(DB_TICKS)) u_lft (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .slew_en (busy),
      .clr     (e_stop),
      .tgt     (lft_eff),
      .cur     (lft_spd),
      .hold    (lft_hold)
   );

   spd_slew #(.STEP(STEP), .DB_TICKS(DB_TICKS)) u_rght (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .slew_en (busy),
      .clr     (e_stop),
      .tgt     (rght_eff),
      .cur     (rght_spd),
      .hold    (rght_hold)
   );

endmodule

// File: tb/tb_mtr_ramp_ctrl.sv
// Directed scoreboard bench for mtr_ramp_ctrl (TICK_DIV=4, STEP=16, DB_TICKS=2).
// Expected speeds are queued per tick and popped after each tick edge.
module tb_mtr_ramp_ctrl;

   logic               clk;
   logic               rst;
   logic               en;
   logic               e_stop;
   logic               cmd_vld;
   logic signed [10:0] lft_cmd;
   logic signed [10:0] rght_cmd;
   logic signed [10:0] lft_spd;
   logic signed [10:0] rght_spd;
   logic               at_target;
   logic               busy;

   typedef struct {
      int l;
      int r;
   } exp_t;

   exp_t     q[$];
   int       checks = 0;
   int       passes = 0;
   logic [1:0] tcnt;

   mtr_ramp_ctrl #(.TICK_DIV(4), .STEP(16), .DB_TICKS(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .e_stop    (e_stop),
      .cmd_vld   (cmd_vld),
      .lft_cmd   (lft_cmd),
      .rght_cmd  (rght_cmd),
      .lft_spd   (lft_spd),
      .rght_spd  (rght_spd),
      .at_target (at_target),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // independent model of the tick phase
   always @(posedge clk) begin
      if (rst) tcnt <= 2'd0;
      else     tcnt <= tcnt + 2'd1;
   end

   task automatic chk(string tag, int got, int exp);
      checks++;
      assert (got === exp) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
   endtask

   task automatic wait_tick();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk);
         if (tcnt == 2'd3) got = 1'b1;
      end
      if (!got) begin
         checks++;
         $error("FAIL tick_timeout: observed none expected tick edge");
      end
      #1;
   endtask

   task automatic push(int l, int r);
      exp_t e;
      e.l = l;
      e.r = r;
      q.push_back(e);
   endtask

   task automatic tick_chk(string tag);
      exp_t e;
      wait_tick();
      if (q.size() == 0) begin
         checks++;
         $error("FAIL %s: observed empty queue expected entry", tag);
      end else begin
         e = q.pop_front();
         chk({tag, "_lft"}, lft_spd, e.l);
         chk({tag, "_rght"}, rght_spd, e.r);
      end
   endtask

   task automatic cmd(int l, int r);
      lft_cmd  = 11'(l);
      rght_cmd = 11'(r);
      cmd_vld  = 1'b1;
      @(posedge clk);
      #1;
      cmd_vld  = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      e_stop   = 1'b0;
      cmd_vld  = 1'b0;
      lft_cmd  = '0;
      rght_cmd = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_lft", lft_spd, 0);
      chk("rst_at", at_target, 1);
      chk("rst_busy", busy, 0);
      rst = 1'b0;

      for (int i = 0; i < 100; i++) begin
         step();
         chk("idle_lft", lft_spd, 0);
         chk("idle_rght", rght_spd, 0);
         chk("idle_at", at_target, 1);
         chk("idle_busy", busy, 0);
      end

      en = 1'b1;
      cmd(100, -40);
      chk("ramp_busy", busy, 1);
      chk("ramp_at0", at_target, 0);
      push(16, -16);  push(32, -32); push(48, -40);
      push(64, -40);  push(80, -40); push(96, -40);
      push(100, -40);
      for (int i = 0; i < 7; i++) tick_chk("ramp");
      chk("ramp_end_busy", busy, 1);
      step();
      chk("hold_busy", busy, 0);
      chk("hold_at", at_target, 1);

      en = 1'b0;
      step();
      chk("stop_busy", busy, 1);
      push(84, -24); push(68, -8); push(52, 0); push(36, 0);
      push(20, 0);   push(4, 0);   push(0, 0);
      for (int i = 0; i < 7; i++) tick_chk("stop");
      step();
      chk("stop_idle_busy", busy, 0);
      chk("stop_idle_at", at_target, 1);

      en = 1'b1;
      cmd(200, 0);
      push(16, 0); push(32, 0); push(48, 0);
      for (int i = 0; i < 3; i++) tick_chk("pre_estop");
      e_stop = 1'b1;
      step();
      chk("estop_lft", lft_spd, 0);
      chk("estop_busy", busy, 0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("estop_hold_lft", lft_spd, 0);
         chk("estop_hold_busy", busy, 0);
      end
      e_stop = 1'b0;
      step();
      chk("estop_rel_busy", busy, 1);
      push(16, 0);
      tick_chk("resume");

      cmd(-1024, 0);
      for (int k = 1; k <= 65; k++) begin
         push((16 - 16 * k < -1023) ? -1023 : 16 - 16 * k, 0);
      end
      for (int k = 0; k < 65; k++) tick_chk("clamp");
      chk("clamp_at", at_target, 1);
      step();
      chk("clamp_hold_busy", busy, 0);

      e_stop = 1'b1;
      step();
      chk("estop2_lft", lft_spd, 0);
      e_stop = 1'b0;
      cmd(32, 0);
      push(16, 0); push(32, 0);
      for (int i = 0; i < 2; i++) tick_chk("db_pre");
      step();
      step();
      chk("db_pre_busy", busy, 0);

      cmd(-32, 0);
      chk("db_busy", busy, 1);
`ifdef MTR_DEADBAND_EN
      push(16, 0); push(0, 0); push(0, 0);
      push(0, 0);  push(-16, 0); push(-32, 0);
      for (int i = 0; i < 6; i++) tick_chk("rev");
`else
      push(16, 0); push(0, 0); push(-16, 0); push(-32, 0);
      for (int i = 0; i < 4; i++) tick_chk("rev");
`endif
      step();
      step();
      chk("rev_hold_busy", busy, 0);
      chk("rev_hold_at", at_target, 1);

      cmd(-32, 0);
      step();
      chk("same_cmd_busy", busy, 0);
      chk("same_cmd_lft", lft_spd, -32);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
